// File: rtl/wb_arbiter.sv
// wb_arbiter: register file writeback arbiter with a pending-write scoreboard.
// Merges the single-cycle pipeline writeback with multiply/divide results.
// Pipeline writes always win the port. Multiply/divide results either bypass
// straight to the port or wait in a small circular queue. A per-register busy
// mask tracks destinations that still await a multiply/divide result.
//
// Ports:
//   clock, ctrl_reset_n          - clock, asynchronous active-low reset
//   pipe_valid/pipe_rd/pipe_data - pipeline writeback request (no backpressure)
//   md_issue/md_issue_rd         - multiply/divide issue, marks destination busy
//   md_valid/md_rd/md_data       - multiply/divide result, accepted when md_ready
//   md_ready                     - queue has room (combinational from count)
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg - registered register file write
//   pend_busy                    - registered per-register pending mask
module wb_arbiter #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_rd,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic [31:0] pend_busy
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [4:0]      ent_rd_q   [DEPTH];
    logic [4:0]      ent_rd_d   [DEPTH];
    logic [31:0]     ent_data_q [DEPTH];
    logic [31:0]     ent_data_d [DEPTH];
    logic [DEPTH-1:0] ent_live_q, ent_live_d;

    logic        we_q, we_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] busy_q, busy_d;

    logic pipe_sel, md_acc, md_live, q_empty, head_live, pop, bypass, push;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pipe_sel  = pipe_valid && (pipe_rd != 5'd0);
        md_ready  = (count_q < CntW'(DEPTH));
        md_acc    = md_valid && md_ready;
        // Stale results (register no longer pending, or r0) are dropped on accept.
        md_live   = md_acc && (md_rd != 5'd0) && busy_q[md_rd];
        q_empty   = (count_q == '0);
        head_live = ent_live_q[head_q];
        // Dead heads still consume a pop cycle so older entries keep priority.
        pop       = !pipe_sel && !q_empty;
        bypass    = !pipe_sel && q_empty && md_live;
        push      = md_live && !bypass;
    end

    always_comb begin
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        ent_live_d = ent_live_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (pipe_sel) begin
            we_d            = 1'b1;
            wreg_d          = pipe_rd;
            wdata_d         = pipe_data;
            busy_d[pipe_rd] = 1'b0;
        end else if (pop && head_live) begin
            we_d                    = 1'b1;
            wreg_d                  = ent_rd_q[head_q];
            wdata_d                 = ent_data_q[head_q];
            busy_d[ent_rd_q[head_q]] = 1'b0;
        end else if (bypass) begin
            we_d          = 1'b1;
            wreg_d        = md_rd;
            wdata_d       = md_data;
            busy_d[md_rd] = 1'b0;
        end

        // Issue is younger than any clear in the same cycle.
        if (md_issue && (md_issue_rd != 5'd0)) begin
            busy_d[md_issue_rd] = 1'b1;
        end

        // Squash: queued results older than a pipeline write to the same rd.
        if (pipe_sel) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_rd_q[i] == pipe_rd) begin
                    ent_live_d[i] = 1'b0;
                end
            end
        end

        if (push) begin
            ent_rd_d[tail_q]   = md_rd;
            ent_data_d[tail_q] = md_data;
            ent_live_d[tail_q] = !(pipe_sel && (pipe_rd == md_rd));
            tail_d             = ptr_inc(tail_q);
        end

        if (pop) begin
            head_d = ptr_inc(head_q);
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            we_q       <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            ent_live_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd_q[i]   <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            we_q       <= we_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            ent_live_q <= ent_live_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd_q[i]   <= ent_rd_d[i];
                ent_data_q[i] <= ent_data_d[i];
            end
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;
    assign pend_busy        = busy_q;

endmodule
